// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Optional XFER watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int DATA_LEN       = 8,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_LEN-1:0]  req_data,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         tx_start,
    output logic [DATA_LEN-1:0]          tx_data,
    input  logic                         tx_busy,
    input  logic                         tx_done,
    output logic [$clog2(NUM_REQ)-1:0]   active_id,
    output logic                         busy,
    output logic                         timeout
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2
    } state_t;

    state_t                state_r;
    logic [ID_W-1:0]       last_id_r;
    logic [ID_W-1:0]       winner_s;
    logic                  found_s;
    logic [DATA_LEN-1:0]   winner_data_s;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]      cnt_r;
    logic                  timeout_r;
    assign timeout = timeout_r;
`else
    assign timeout = 1'b0;
`endif

    // Round-robin search starting one past the previous winner
    always_comb begin
        winner_s = last_id_r;
        found_s  = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found_s && req[(int'(last_id_r) + i) % NUM_REQ]) begin
                found_s  = 1'b1;
                winner_s = ID_W'((int'(last_id_r) + i) % NUM_REQ);
            end else begin
                winner_s = winner_s;
            end
        end
    end

    assign winner_data_s = req_data[winner_s*DATA_LEN +: DATA_LEN];

    // Arbitration FSM with registered outputs; grant/tx_start are set on the
    // IDLE->START edge so they are visible exactly during START
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            grant     <= {NUM_REQ{1'b0}};
            tx_start  <= 1'b0;
            tx_data   <= {DATA_LEN{1'b0}};
            busy      <= 1'b0;
            active_id <= {ID_W{1'b0}};
            last_id_r <= ID_W'(NUM_REQ - 1);
`ifdef UART_TX_ARB_TIMEOUT_EN
            cnt_r     <= {CNT_W{1'b0}};
            timeout_r <= 1'b0;
`endif
        end else begin
            grant    <= {NUM_REQ{1'b0}};
            tx_start <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (found_s && !tx_busy) begin
                        state_r   <= START;
                        tx_data   <= winner_data_s;
                        active_id <= winner_s;
                        grant     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_s;
                        tx_start  <= 1'b1;
                        busy      <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                START: begin
                    state_r <= XFER;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    cnt_r   <= {CNT_W{1'b0}};
`endif
                end
                XFER: begin
                    if (tx_done) begin
                        state_r   <= IDLE;
                        last_id_r <= active_id;
                        busy      <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    end else if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_r   <= IDLE;
                        last_id_r <= active_id;
                        busy      <= 1'b0;
                        timeout_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
`else
                    end else begin
                        state_r <= XFER;
`endif
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
